exe_stage: RTL and testbench

Execute stage of the 16-bit five-stage pipeline, directly downstream of the ID/EXE pipeline register. Selects operands (register bus, immediate, or forwarded result), performs the 3-bit ALU operation, and captures the result, store data and pass-through control into an internal EXE/MEM register with stall, flush and condition flags. All outputs are registered and feed the memory stage.

---
 rtl/cpu_pkg.sv | 44 ++++
 rtl/exe_stage_if.sv | 32 +++
 rtl/alu16.sv | 36 +++
 rtl/exe_stage.sv | 60 ++++++
 tb/tb_exe_stage.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit five-stage pipeline: datapath width, ALU opcodes,
// the EXE/MEM register layout and the operand forwarding selector.
package cpu_pkg;
  localparam int W = 16;

  localparam logic [2:0] REG0      = 3'd0;
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_OR    = 3'b011;
  localparam logic [2:0] ALU_XOR   = 3'b100;
  localparam logic [2:0] ALU_SLL   = 3'b101;
  localparam logic [2:0] ALU_SRL   = 3'b110;
  localparam logic [2:0] ALU_PASSB = 3'b111;

  typedef struct packed {
    logic         valid;
    logic         regwr;
    logic         memr;
    logic         memw;
    logic         wb;
    logic [2:0]   rd;
    logic [W-1:0] res;
    logic [W-1:0] sdata;
    logic         zero;
    logic         neg;
    logic         carry;
  } exmem_t;

  // EXE/MEM beats WB; a load in EXE/MEM has no data yet so it is skipped.
  function automatic logic [W-1:0] fwd_sel(
    input logic [2:0]   rs,
    input logic [W-1:0] bus,
    input exmem_t       q,
    input logic         wb_wr,
    input logic [2:0]   wb_rd,
    input logic [W-1:0] wb_data
  );
    if (rs == REG0)                                   return '0;
    if (q.valid && q.regwr && !q.memr && q.rd == rs)  return q.res;
    if (wb_wr && wb_rd == rs)                         return wb_data;
    return bus;
  endfunction
endpackage

// File: rtl/exe_stage_if.sv
// ID/EXE inputs, write-back forwarding, pipeline control and EXE/MEM outputs of the execute stage.
interface exe_stage_if;
  import cpu_pkg::*;
  logic [2:0]   Rd2In, Rs1In, Rs2In;
  logic         RegWrIn, MemRIn, MemWIn, WBIn;
  logic [2:0]   ALUOpIn;
  logic         ALUSrc1_SignalIn, ALUSrc2_SignalIn;
  logic [W-1:0] ImmIn, Bus1In, Bus2In;
  logic [2:0]   WbRdIn;
  logic         WbRegWrIn;
  logic [W-1:0] WbDataIn;
  logic         StallIn, FlushIn;
  logic [W-1:0] ResultOut, StoreDataOut;
  logic [2:0]   Rd2Out;
  logic         RegWrOut, MemROut, MemWOut, WBOut, ValidOut;
  logic         ZeroOut, NegOut, CarryOut;

  modport master (
    output Rd2In, Rs1In, Rs2In, RegWrIn, MemRIn, MemWIn, WBIn, ALUOpIn,
           ALUSrc1_SignalIn, ALUSrc2_SignalIn, ImmIn, Bus1In, Bus2In,
           WbRdIn, WbRegWrIn, WbDataIn, StallIn, FlushIn,
    input  ResultOut, StoreDataOut, Rd2Out, RegWrOut, MemROut, MemWOut, WBOut,
           ValidOut, ZeroOut, NegOut, CarryOut
  );
  modport slave (
    input  Rd2In, Rs1In, Rs2In, RegWrIn, MemRIn, MemWIn, WBIn, ALUOpIn,
           ALUSrc1_SignalIn, ALUSrc2_SignalIn, ImmIn, Bus1In, Bus2In,
           WbRdIn, WbRegWrIn, WbDataIn, StallIn, FlushIn,
    output ResultOut, StoreDataOut, Rd2Out, RegWrOut, MemROut, MemWOut, WBOut,
           ValidOut, ZeroOut, NegOut, CarryOut
  );
endinterface

// File: rtl/alu16.sv
// Combinational 3-bit-opcode ALU; carry is the W+1 bit of ADD/SUB (1 = no borrow on SUB).
module alu16
  import cpu_pkg::*;
(
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic [2:0]   i_op,
  output logic [W-1:0] o_res,
  output logic         o_carry
);
  logic [W:0] w_sum;

  always_comb begin
    w_sum   = '0;
    o_res   = '0;
    o_carry = 1'b0;
    unique case (i_op)
      ALU_ADD: begin
        w_sum   = {1'b0, i_a} + {1'b0, i_b};
        o_res   = w_sum[W-1:0];
        o_carry = w_sum[W];
      end
      ALU_SUB: begin
        w_sum   = {1'b0, i_a} + {1'b0, ~i_b} + {{W{1'b0}}, 1'b1};
        o_res   = w_sum[W-1:0];
        o_carry = w_sum[W];
      end
      ALU_AND: o_res = i_a & i_b;
      ALU_OR:  o_res = i_a | i_b;
      ALU_XOR: o_res = i_a ^ i_b;
      ALU_SLL: o_res = i_a << i_b[3:0];
      ALU_SRL: o_res = i_a >> i_b[3:0];
      default: o_res = i_b;
    endcase
  end
endmodule

// File: rtl/exe_stage.sv
// Execute stage: forwarding muxes, operand select, ALU, and the EXE/MEM register
// with flush-over-stall priority.
module exe_stage
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  exe_stage_if.slave  bus
);
  exmem_t       r_q, w_d;
  logic [W-1:0] w_fa, w_fb, w_a, w_b, w_res;
  logic         w_carry;

  // Forwarding compares against r_q even while stalled, so held results stay visible.
  assign w_fa = fwd_sel(bus.Rs1In, bus.Bus1In, r_q, bus.WbRegWrIn, bus.WbRdIn, bus.WbDataIn);
  assign w_fb = fwd_sel(bus.Rs2In, bus.Bus2In, r_q, bus.WbRegWrIn, bus.WbRdIn, bus.WbDataIn);
  assign w_a  = bus.ALUSrc1_SignalIn ? bus.ImmIn : w_fa;
  assign w_b  = bus.ALUSrc2_SignalIn ? bus.ImmIn : w_fb;

  alu16 u_alu (
    .i_a    (w_a),
    .i_b    (w_b),
    .i_op   (bus.ALUOpIn),
    .o_res  (w_res),
    .o_carry(w_carry)
  );

  always_comb begin
    w_d       = '0;
    w_d.valid = 1'b1;
    w_d.regwr = bus.RegWrIn;
    w_d.memr  = bus.MemRIn;
    w_d.memw  = bus.MemWIn;
    w_d.wb    = bus.WBIn;
    w_d.rd    = bus.Rd2In;
    w_d.res   = w_res;
    w_d.sdata = w_fb;
    w_d.zero  = (w_res == '0);
    w_d.neg   = w_res[W-1];
    w_d.carry = w_carry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)            r_q <= '0;
    else if (bus.FlushIn)  r_q <= '0;
    else if (!bus.StallIn) r_q <= w_d;
  end

  assign bus.ResultOut    = r_q.res;
  assign bus.StoreDataOut = r_q.sdata;
  assign bus.Rd2Out       = r_q.rd;
  assign bus.RegWrOut     = r_q.regwr;
  assign bus.MemROut      = r_q.memr;
  assign bus.MemWOut      = r_q.memw;
  assign bus.WBOut        = r_q.wb;
  assign bus.ValidOut     = r_q.valid;
  assign bus.ZeroOut      = r_q.zero;
  assign bus.NegOut       = r_q.neg;
  assign bus.CarryOut     = r_q.carry;
endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: a reference model predicts each EXE/MEM capture at drive time.
module tb_exe_stage;
  import cpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  exe_stage_if bus ();
  exe_stage dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));

  int     n_chk = 0;
  int     n_pass = 0;
  exmem_t m = '0;
  exmem_t sb[$];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
  endtask

  function automatic logic [15:0] mfwd(input logic [2:0] rs, input logic [15:0] rbus);
    if (rs == 3'd0) return 16'h0;
    if (m.valid && m.regwr && !m.memr && m.rd == rs) return m.res;
    if (bus.WbRegWrIn && bus.WbRdIn == rs) return bus.WbDataIn;
    return rbus;
  endfunction

  task automatic alu_ref(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                         output logic [15:0] r, output logic c);
    logic [16:0] s;
    c = 1'b0;
    case (op)
      3'd0: begin s = 17'(a) + 17'(b); r = s[15:0]; c = s[16]; end
      3'd1: begin r = a - b; c = (a >= b); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = a << b[3:0];
      3'd6: r = a >> b[3:0];
      default: r = b;
    endcase
  endtask

  task automatic set_ins(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, input logic [15:0] b1, input logic [15:0] b2,
                         input logic [15:0] imm, input logic s1, input logic s2,
                         input logic rw, input logic mr, input logic mw);
    bus.ALUOpIn = op; bus.Rd2In = rd; bus.Rs1In = rs1; bus.Rs2In = rs2;
    bus.Bus1In = b1; bus.Bus2In = b2; bus.ImmIn = imm;
    bus.ALUSrc1_SignalIn = s1; bus.ALUSrc2_SignalIn = s2;
    bus.RegWrIn = rw; bus.MemRIn = mr; bus.MemWIn = mw; bus.WBIn = rw;
    bus.StallIn = 1'b0; bus.FlushIn = 1'b0;
  endtask

  // Predict, push, clock, then pop and compare the registered outputs.
  task automatic cyc(input string tag);
    exmem_t e;
    logic [15:0] fa, fb, a, b, r;
    logic c;
    e = '0;
    if (bus.FlushIn) e = '0;
    else if (bus.StallIn) e = m;
    else begin
      fa = mfwd(bus.Rs1In, bus.Bus1In);
      fb = mfwd(bus.Rs2In, bus.Bus2In);
      a  = bus.ALUSrc1_SignalIn ? bus.ImmIn : fa;
      b  = bus.ALUSrc2_SignalIn ? bus.ImmIn : fb;
      alu_ref(bus.ALUOpIn, a, b, r, c);
      e.valid = 1'b1; e.regwr = bus.RegWrIn; e.memr = bus.MemRIn; e.memw = bus.MemWIn;
      e.wb = bus.WBIn; e.rd = bus.Rd2In; e.res = r; e.sdata = fb;
      e.zero = (r == 16'h0); e.neg = r[15]; e.carry = c;
    end
    sb.push_back(e);
    @(posedge clk); #1;
    e = sb.pop_front();
    chk({tag, ".res"},   32'(bus.ResultOut),    32'(e.res));
    chk({tag, ".sdata"}, 32'(bus.StoreDataOut), 32'(e.sdata));
    chk({tag, ".ctl"},
        32'({bus.ValidOut, bus.RegWrOut, bus.MemROut, bus.MemWOut, bus.WBOut, bus.Rd2Out}),
        32'({e.valid, e.regwr, e.memr, e.memw, e.wb, e.rd}));
    chk({tag, ".flags"}, 32'({bus.ZeroOut, bus.NegOut, bus.CarryOut}),
        32'({e.zero, e.neg, e.carry}));
    m = e;
  endtask

  initial begin
    set_ins(3'd0, 3'd0, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    bus.WbRdIn = 3'd0; bus.WbRegWrIn = 1'b0; bus.WbDataIn = 16'h0;
    #12;
    chk("rst.valid", 32'(bus.ValidOut), 32'd0);
    chk("rst.res",   32'(bus.ResultOut), 32'd0);
    rst_n = 1'b1;

    set_ins(ALU_ADD, 3'd1, 3'd2, 3'd3, 16'h7FFF, 16'h0001, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("add");
    chk("add.lit", 32'({bus.ResultOut, bus.NegOut, bus.ZeroOut, bus.CarryOut}),
        32'({16'h8000, 3'b100}));

    set_ins(ALU_SUB, 3'd6, 3'd4, 3'd5, 16'h0005, 16'h0005, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("sub");
    chk("sub.lit", 32'({bus.ResultOut, bus.ZeroOut, bus.CarryOut}), 32'({16'h0000, 2'b11}));

    set_ins(ALU_ADD, 3'd1, 3'd2, 3'd3, 16'h0008, 16'h0008, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("fw0");
    set_ins(ALU_ADD, 3'd4, 3'd1, 3'd1, 16'hDEAD, 16'hDEAD, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("fwex");
    chk("fwex.lit", 32'(bus.ResultOut), 32'h0020);

    bus.FlushIn = 1'b1;
    cyc("flush");

    set_ins(ALU_OR, 3'd5, 3'd2, 3'd7, 16'h0, 16'h0, 16'h000F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    bus.WbRegWrIn = 1'b1; bus.WbRdIn = 3'd2; bus.WbDataIn = 16'h1234;
    cyc("wbfw");
    chk("wbfw.lit", 32'(bus.ResultOut), 32'h123F);

    set_ins(ALU_PASSB, 3'd2, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("wr_r2");
    set_ins(ALU_OR, 3'd5, 3'd2, 3'd7, 16'h0, 16'h0, 16'h000F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("prio");
    chk("prio.lit", 32'(bus.ResultOut), 32'h000F);
    bus.WbRegWrIn = 1'b0;

    set_ins(ALU_PASSB, 3'd3, 3'd0, 3'd0, 16'h0, 16'h0, 16'h0040, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    cyc("load");
    set_ins(ALU_ADD, 3'd5, 3'd3, 3'd0, 16'h0100, 16'h0, 16'h0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc("ldnofw");
    chk("ldnofw.lit", 32'(bus.ResultOut), 32'h0100);

    for (int i = 0; i < 24; i++) begin
      set_ins(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)), 3'($urandom_range(1, 7)),
              3'($urandom_range(1, 7)), 16'($urandom), 16'($urandom), 16'($urandom),
              1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
              1'($urandom_range(0, 1)), 1'b0);
      bus.WbRegWrIn = 1'($urandom_range(0, 1));
      bus.WbRdIn = 3'($urandom_range(0, 7));
      bus.WbDataIn = 16'($urandom);
      cyc("rnd");
    end
    bus.WbRegWrIn = 1'b0;

    set_ins(ALU_ADD, 3'd0, 3'd6, 3'd7, 16'h0010, 16'h0020, 16'h0004, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    cyc("store");
    for (int i = 0; i < 3; i++) begin
      set_ins(ALU_XOR, 3'd4, 3'd1, 3'd2, 16'($urandom), 16'($urandom), 16'h0, 1'b0, 1'b0,
              1'b1, 1'b0, 1'b0);
      bus.StallIn = 1'b1;
      cyc("stall");
    end
    chk("stall.memw", 32'(bus.MemWOut), 32'd1);
    chk("stall.res",  32'(bus.ResultOut), 32'h0014);

    bus.StallIn = 1'b1; bus.FlushIn = 1'b1;
    cyc("stfl");
    chk("stfl.lit", 32'({bus.ValidOut, bus.MemWOut}), 32'd0);

    set_ins(ALU_SLL, 3'd1, 3'd2, 3'd0, 16'h0003, 16'h0, 16'h0004, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("sll");
    chk("sll.lit", 32'(bus.ResultOut), 32'h0030);

    #2 rst_n = 1'b0;
    #1;
    chk("mrst.valid", 32'(bus.ValidOut), 32'd0);
    chk("mrst.res",   32'(bus.ResultOut), 32'd0);
    bus.StallIn = 1'b1;
    @(posedge clk); #1;
    chk("mrst.hold", 32'({bus.ValidOut, bus.RegWrOut, bus.ResultOut}), 32'd0);
    #2 rst_n = 1'b1;
    m = '0;
    set_ins(ALU_SRL, 3'd2, 3'd1, 3'd0, 16'h8000, 16'h0, 16'h000F, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    cyc("srl");
    chk("srl.lit", 32'(bus.ResultOut), 32'h0001);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
